sdram_ctrl: RTL and testbench

- Single-port SDR SDRAM controller for one MT48LC8M16A2 device: 8M x16, 4 banks, 4096 rows, 512 columns.
- Host side: single-word write and read requests with a busy/ready handshake.
- SDRAM side: drives the command, address and data pins directly, clocked from the same clock as the host logic (50 MHz nominal).
- Handles power-up initialisation and periodic auto-refresh internally. Every access opens a row and closes it with auto-precharge.

---
 rtl/sdram_ctrl_if.sv | 22 ++
 rtl/sdram_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_sdram_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_ctrl_if.sv
// Host-side request/response bundle for sdram_ctrl: single-word write and read
// requests with a busy/ready handshake.
interface sdram_ctrl_if;
  logic [22:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_enable;
  logic [22:0] rd_addr;
  logic        rd_enable;
  logic [15:0] rd_data;
  logic        rd_ready;
  logic        busy;

  modport master (
    output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    input  rd_data, rd_ready, busy
  );

  modport slave (
    input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    output rd_data, rd_ready, busy
  );
endinterface

// File: rtl/sdram_ctrl.sv
// Single-port SDR SDRAM controller for one MT48LC8M16A2: power-up init, periodic
// auto-refresh and single-word accesses that always close the row with auto-precharge.
module sdram_ctrl #(
  parameter int unsigned INIT_WAIT_CYCLES = 5000,
  parameter int unsigned REFRESH_CYCLES   = 390,
  parameter int unsigned CAS_LATENCY      = 2,
  parameter int unsigned T_RP             = 1,
  parameter int unsigned T_RCD            = 1,
  parameter int unsigned T_RFC            = 4,
  parameter int unsigned T_MRD            = 2,
  parameter int unsigned T_WR_RP          = 3
) (
  input  logic        clk,
  input  logic        rst,
  sdram_ctrl_if.slave host,
  output logic [11:0] addr,
  output logic [1:0]  bank_addr,
  inout  wire  [15:0] data,
  output logic        clock_enable,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic        data_mask_low,
  output logic        data_mask_high
);

  localparam logic [3:0] CmdNop       = 4'b0111;
  localparam logic [3:0] CmdActive    = 4'b0011;
  localparam logic [3:0] CmdRead      = 4'b0101;
  localparam logic [3:0] CmdWrite     = 4'b0100;
  localparam logic [3:0] CmdPrecharge = 4'b0010;
  localparam logic [3:0] CmdRefresh   = 4'b0001;
  localparam logic [3:0] CmdLoadMode  = 4'b0000;
  localparam logic [3:0] CmdDeselect  = 4'b1111;

  // BL=1, sequential, CAS latency in A[6:4], burst write
  localparam logic [11:0] ModeWord = {5'b00000, 3'(CAS_LATENCY), 4'b0000};

  typedef enum logic [3:0] {
    StInitWait, StInitPre, StInitRef1, StInitRef2, StInitMrs, StIdle, StRefresh,
    StActivate, StRcdWait, StWrite, StRead, StClWait, StDoneWait
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  bank_q, bank_d;
  logic        cke_q;
  logic        dqm_q, dqm_d;
  logic        drive_q, drive_d;
  logic [15:0] wdata_q, wdata_d;
  logic [8:0]  col_q, col_d;
  logic        is_write_q, is_write_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_ready_q, rd_ready_d;
  logic        init_done_q, init_done_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        refresh_due_q, refresh_due_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = CmdNop;
    addr_d        = addr_q;
    bank_d        = bank_q;
    dqm_d         = dqm_q;
    drive_d       = 1'b0;
    wdata_d       = wdata_q;
    col_d         = col_q;
    is_write_d    = is_write_q;
    rd_data_d     = rd_data_q;
    rd_ready_d    = 1'b0;
    init_done_d   = init_done_q;
    ref_cnt_d     = ref_cnt_q;
    refresh_due_d = refresh_due_q;

    // A state is entered on the cycle its command is on the pins; cnt_q counts the
    // remaining cycles spent in it.
    unique case (state_q)
      StInitWait: begin
        if (cnt_q == '0) begin
          cmd_d   = CmdPrecharge;
          addr_d  = 12'h400;
          state_d = StInitPre;
          cnt_d   = 16'(T_RP);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StInitPre, StInitRef1: begin
        if (cnt_q == '0) begin
          cmd_d   = CmdRefresh;
          state_d = (state_q == StInitPre) ? StInitRef1 : StInitRef2;
          cnt_d   = 16'(T_RFC);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StInitRef2: begin
        if (cnt_q == '0) begin
          cmd_d   = CmdLoadMode;
          addr_d  = ModeWord;
          bank_d  = 2'b00;
          state_d = StInitMrs;
          cnt_d   = 16'(T_MRD);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StInitMrs: begin
        if (cnt_q == '0) begin
          state_d     = StIdle;
          dqm_d       = 1'b0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StIdle: begin
        if (refresh_due_q) begin
          cmd_d         = CmdRefresh;
          refresh_due_d = 1'b0;
          state_d       = StRefresh;
          cnt_d         = 16'(T_RFC);
        end else if (host.wr_enable) begin
          cmd_d      = CmdActive;
          bank_d     = host.wr_addr[22:21];
          addr_d     = host.wr_addr[20:9];
          col_d      = host.wr_addr[8:0];
          wdata_d    = host.wr_data;
          is_write_d = 1'b1;
          state_d    = StActivate;
        end else if (host.rd_enable) begin
          cmd_d      = CmdActive;
          bank_d     = host.rd_addr[22:21];
          addr_d     = host.rd_addr[20:9];
          col_d      = host.rd_addr[8:0];
          is_write_d = 1'b0;
          state_d    = StActivate;
        end
      end
      StRefresh, StDoneWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StActivate: begin
        state_d = StRcdWait;
        cnt_d   = 16'(T_RCD - 1);
      end
      StRcdWait: begin
        if (cnt_q == '0) begin
          addr_d = {3'b010, col_q};
          if (is_write_q) begin
            cmd_d   = CmdWrite;
            drive_d = 1'b1;
            state_d = StWrite;
          end else begin
            cmd_d   = CmdRead;
            state_d = StRead;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StWrite: begin
        state_d = StDoneWait;
        cnt_d   = 16'(T_WR_RP - 1);
      end
      StRead: begin
        state_d = StClWait;
        cnt_d   = 16'(CAS_LATENCY - 1);
      end
      StClWait: begin
        if (cnt_q == '0) begin
          rd_data_d  = data;
          rd_ready_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StInitWait;
        cnt_d   = 16'(INIT_WAIT_CYCLES);
      end
    endcase

    // A new refresh request wins over the clear issued in the same cycle.
    if (init_done_q) begin
      if (ref_cnt_q == 16'(REFRESH_CYCLES - 1)) begin
        ref_cnt_d     = '0;
        refresh_due_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StInitWait;
      cnt_q         <= 16'(INIT_WAIT_CYCLES);
      cmd_q         <= CmdDeselect;
      addr_q        <= '0;
      bank_q        <= '0;
      cke_q         <= 1'b0;
      dqm_q         <= 1'b1;
      drive_q       <= 1'b0;
      wdata_q       <= '0;
      col_q         <= '0;
      is_write_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_ready_q    <= 1'b0;
      init_done_q   <= 1'b0;
      ref_cnt_q     <= '0;
      refresh_due_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      bank_q        <= bank_d;
      cke_q         <= 1'b1;
      dqm_q         <= dqm_d;
      drive_q       <= drive_d;
      wdata_q       <= wdata_d;
      col_q         <= col_d;
      is_write_q    <= is_write_d;
      rd_data_q     <= rd_data_d;
      rd_ready_q    <= rd_ready_d;
      init_done_q   <= init_done_d;
      ref_cnt_q     <= ref_cnt_d;
      refresh_due_q <= refresh_due_d;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign addr           = addr_q;
  assign bank_addr      = bank_q;
  assign clock_enable   = cke_q;
  assign data_mask_low  = dqm_q;
  assign data_mask_high = dqm_q;
  assign data           = drive_q ? wdata_q : 16'hzzzz;

  assign host.busy     = (state_q != StIdle) | refresh_due_q;
  assign host.rd_data  = rd_data_q;
  assign host.rd_ready = rd_ready_q;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl: init sequence, write/read timing with a small
// CL=2 device model, refresh spacing, request rejection and mid-access reset.
module tb_sdram_ctrl;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sdram_ctrl_if host ();

  wire [11:0] addr;
  wire [1:0]  bank_addr;
  wire [15:0] data;
  wire        clock_enable, cs_n, ras_n, cas_n, we_n, dqml, dqmh;
  wire [3:0]  cmd = {cs_n, ras_n, cas_n, we_n};

  sdram_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .host           (host),
    .addr           (addr),
    .bank_addr      (bank_addr),
    .data           (data),
    .clock_enable   (clock_enable),
    .cs_n           (cs_n),
    .ras_n          (ras_n),
    .cas_n          (cas_n),
    .we_n           (we_n),
    .data_mask_low  (dqml),
    .data_mask_high (dqmh)
  );

  // Device model: stores by {bank, column}; READ data is driven for the cycle
  // that ends with the CL=2 sampling edge.
  logic [15:0] mem [0:2047];
  logic [15:0] dq_drv = 16'h0;
  logic        dq_oe  = 1'b0;
  int          rd_delay = 0;
  logic [10:0] rd_key = '0;
  assign data = dq_oe ? dq_drv : 16'hzzzz;

  always @(negedge clk) begin
    dq_oe <= 1'b0;
    if (rd_delay == 1) begin
      dq_oe  <= 1'b1;
      dq_drv <= mem[rd_key];
    end
    if (rd_delay != 0) rd_delay <= rd_delay - 1;
    if (clock_enable && cmd == CMD_WR) mem[{bank_addr, addr[8:0]}] <= data;
    if (clock_enable && cmd == CMD_RD) begin
      rd_delay <= 2;
      rd_key   <= {bank_addr, addr[8:0]};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  logic busy_dropped;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cmd(output logic [3:0] c, output int nops);
    logic found = 1'b0;
    nops = 0;
    c = CMD_NOP;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (!host.busy) busy_dropped = 1'b1;
      if (cmd != CMD_NOP) begin
        c = cmd;
        found = 1'b1;
      end else begin
        nops++;
      end
    end
    if (!found) check_value("next_cmd_timeout", 32'(found), 1);
  endtask

  task automatic wait_idle();
    logic found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (!host.busy) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) check_value("wait_idle_timeout", 32'(found), 1);
  endtask

  // Called at a negedge after at least one reset edge.
  task automatic check_init();
    logic [3:0] c;
    int n;
    check_value("rst_cmd", 32'(cmd), 32'hF);
    check_value("rst_cke", 32'(clock_enable), 0);
    check_value("rst_addr", 32'({bank_addr, addr}), 0);
    check_value("rst_dq", 32'(data), 32'(16'hzzzz));
    check_value("rst_dqm", 32'({dqml, dqmh}), 3);
    check_value("rst_busy", 32'(host.busy), 1);
    check_value("rst_rd", 32'({host.rd_ready, host.rd_data}), 0);
    rst = 1'b0;
    busy_dropped = 1'b0;
    next_cmd(c, n);
    check_value("init_nops", 32'(n), 5000);
    check_value("init_cke", 32'(clock_enable), 1);
    check_value("init_pre", 32'({c, addr[10]}), 32'({CMD_PRE, 1'b1}));
    next_cmd(c, n);
    check_value("init_ref1", 32'({c, 4'(n)}), 32'({CMD_REF, 4'd1}));
    next_cmd(c, n);
    check_value("init_ref2", 32'({c, 4'(n)}), 32'({CMD_REF, 4'd4}));
    next_cmd(c, n);
    check_value("init_lmr", 32'({c, 4'(n)}), 32'({CMD_LMR, 4'd4}));
    check_value("init_lmr_addr", 32'({bank_addr, addr}), 32'h020);
    repeat (2) begin
      @(negedge clk);
      if (!host.busy) busy_dropped = 1'b1;
    end
    check_value("init_busy", 32'(busy_dropped), 0);
    check_value("init_dqm_held", 32'({dqml, dqmh}), 3);
    @(negedge clk);
    check_value("init_done_busy", 32'(host.busy), 0);
    check_value("init_dqm", 32'({dqml, dqmh}), 0);
  endtask

  task automatic do_write(input logic [22:0] a, input logic [15:0] d, input logic also_rd);
    int hi = 0;
    int rdy = 0;
    wait_idle();
    host.wr_addr   = a;
    host.wr_data   = d;
    host.wr_enable = 1'b1;
    host.rd_addr   = 23'h0;
    host.rd_enable = also_rd;
    @(negedge clk);
    host.wr_enable = 1'b0;
    host.rd_enable = 1'b0;
    check_value("wr_act", 32'({cmd, bank_addr, addr}), 32'({CMD_ACT, a[22:21], a[20:9]}));
    check_value("wr_busy", 32'(host.busy), 1);
    @(negedge clk);
    check_value("wr_rcd", 32'({cmd, data}), 32'({CMD_NOP, 16'hzzzz}));
    @(negedge clk);
    check_value("wr_cmd", 32'({cmd, bank_addr, addr}), 32'({CMD_WR, a[22:21], 3'b010, a[8:0]}));
    check_value("wr_dq", 32'(data), 32'(d));
    @(negedge clk);
    check_value("wr_dq_release", 32'(data), 32'(16'hzzzz));
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      if (host.busy) hi++;
      if (host.rd_ready) rdy++;
    end
    check_value("wr_recovery", 32'(hi), 3);
    check_value("wr_no_rd", 32'(rdy), 0);
    @(negedge clk);
    check_value("wr_idle", 32'({host.busy, cmd}), 32'({1'b0, CMD_NOP}));
  endtask

  task automatic do_read(input logic [22:0] a, input logic [15:0] exp);
    int early = 0;
    wait_idle();
    host.rd_addr   = a;
    host.rd_enable = 1'b1;
    @(negedge clk);
    host.rd_enable = 1'b0;
    check_value("rd_act", 32'({cmd, bank_addr, addr}), 32'({CMD_ACT, a[22:21], a[20:9]}));
    @(negedge clk);
    check_value("rd_rcd", 32'(cmd), 32'(CMD_NOP));
    @(negedge clk);
    check_value("rd_cmd", 32'({cmd, bank_addr, addr}), 32'({CMD_RD, a[22:21], 3'b010, a[8:0]}));
    repeat (2) begin
      @(negedge clk);
      if (host.rd_ready) early++;
      if (!host.busy) early++;
    end
    check_value("rd_early", 32'(early), 0);
    @(negedge clk);
    check_value("rd_ready", 32'(host.rd_ready), 1);
    check_value("rd_data", 32'(host.rd_data), 32'(exp));
    check_value("rd_idle", 32'(host.busy), 0);
    @(negedge clk);
    check_value("rd_pulse", 32'(host.rd_ready), 0);
    check_value("rd_hold", 32'(host.rd_data), 32'(exp));
  endtask

  task automatic wait_ref(output int t, output int other, output logic busy_before);
    logic found = 1'b0;
    logic prev = 1'b0;
    t = 0;
    other = 0;
    busy_before = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (cmd == CMD_REF) begin
        t = cyc;
        busy_before = prev;
        found = 1'b1;
      end else if (cmd != CMD_NOP) begin
        other++;
      end
      prev = host.busy;
    end
    if (!found) check_value("wait_ref_timeout", 32'(found), 1);
  endtask

  initial begin
    int   t1, t2, other;
    logic bb;
    host.wr_addr   = '0;
    host.wr_data   = '0;
    host.wr_enable = 1'b0;
    host.rd_addr   = '0;
    host.rd_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_init();

    do_write(23'h000000, 16'h5555, 1'b0);
    do_read(23'h000000, 16'h5555);
    // Simultaneous request: the write must win
    do_write(23'h424645, 16'h1234, 1'b1);
    do_read(23'h424645, 16'h1234);

    wait_ref(t1, other, bb);
    check_value("ref_busy_before", 32'(bb), 1);
    check_value("ref_busy", 32'(host.busy), 1);
    host.rd_addr   = 23'h0;
    host.rd_enable = 1'b1;
    @(negedge clk);
    host.rd_enable = 1'b0;
    check_value("ref_busy_trfc", 32'(host.busy), 1);
    wait_ref(t2, other, bb);
    check_value("ref_period", 32'(t2 - t1), 390);
    check_value("ref_rd_ignored", 32'(other), 0);

    wait_idle();
    host.wr_addr   = 23'h000010;
    host.wr_data   = 16'hbeef;
    host.wr_enable = 1'b1;
    @(negedge clk);
    host.wr_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_value("mid_wr_cmd", 32'({cmd, data}), 32'({CMD_WR, 16'hbeef}));
    rst = 1'b1;
    @(negedge clk);
    check_init();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
